lz77_token_scheduler: RTL
=========================

// Module: lz77_token_scheduler
// PURPOSE
//  Sequences AXI-Stream LZ77 tokens into lz77_decomp_core, which has no output backpressure.
//  Issues a token only when the downstream byte buffer holds >= length+1 free slots.
//  Counts in-flight bytes and tracks frame boundaries (tlast); pulses frame_done after the last byte.
//  Flags illegal back-references. Sits between the s_axis ingress and the core; credits return from the output FIFO.
// PARAMETERS
//  DIST_WIDTH  4   distance field width (matches core)
//  LEN_WIDTH   4   length field width (matches core)
//  CREDITS     32  downstream buffer depth in bytes; must be >= 2**LEN_WIDTH (elaboration $error otherwise)
// PORTS
//  clk             in   1    single clock, all logic on posedge
//  rst             in   1    synchronous, active-high reset
//  s_axis_tvalid   in   1    token valid
//  s_axis_tready   out  1    token ready
//  s_axis_tdata    in   D+L+8  {distance, length, literal}, literal in [7:0]
//  s_axis_tlast    in   1    token is last of frame
//  core_in_valid   out  1    token valid to core
//  core_in_ready   in   1    core ready (core IDLE)
//  core_distance   out  DIST_WIDTH  held distance
//  core_length     out  LEN_WIDTH   held length
//  core_literal    out  8    held literal
//  core_out_valid  in   1    core emitted one byte this cycle
//  credit_return   in   1    downstream popped one byte (returns one credit)
//  busy            out  1    state != S_IDLE or pending != 0
//  frame_done      out  1    one-cycle pulse: last byte of frame emitted
//  err_dist        out  1    sticky: illegal back-reference seen
// BEHAVIOUR
//  Reset: state=S_IDLE; credits=CREDITS; pending=0; wr_cnt=0. Outputs s_axis_tready=1, core_in_valid=0,
//   core_* fields=0, frame_done=0, err_dist=0. Integration drives the core's rst_n = ~rst, so both reset together.
//  need = length + 1, computed at LEN_WIDTH+1 bits (no overflow).
//  credits are $clog2(CREDITS+1) bits. Update per cycle: credits - (issue ? need : 0) + credit_return.
//  pending is the same width. Update per cycle: pending + (issue ? need : 0) - core_out_valid.
//  issue = core_in_valid && core_in_ready.
//  States:
//   S_IDLE
//    - s_axis_tready=1.
//    - On tvalid: latch fields and tlast into a holding register; go to S_HOLD next cycle.
//    - Min latency: accept at cycle N, earliest core_in_valid at N+1.
//   S_HOLD
//    - s_axis_tready=0; core_in_valid = (credits >= need).
//    - core_* fields stable while held; valid never drops before issue unless rst.
//    - On issue: if held tlast, go to S_DRAIN; else go to S_IDLE.
//   S_DRAIN
//    - s_axis_tready=0.
//    - When pending==0 (after the update): frame_done=1 for exactly one cycle, wr_cnt cleared, go to S_IDLE.
//  credit_return coincident with issue: both applied in the same cycle.
//   - credit_return with credits==CREDITS is ignored (saturate, no wrap).
//  core_out_valid with pending==0: pending stays 0 (no underflow).
//  Distance check, evaluated on issue:
//   - length!=0 and (distance==0 or distance > wr_cnt): set err_dist.
//   - The token is still issued; err_dist clears only on rst.
//  wr_cnt counts bytes issued in the current frame and saturates at 2**DIST_WIDTH.
//  length==0 token: need=1; literal-only; same flow.
//  rst asserted mid-token or mid-drain: everything returns to reset values next cycle; the held token is discarded.
// TESTING
//  T1 literal frame: tokens (0,0,'A'),(0,0,'B' tlast), credits 32 -> 2 core issues, credits 30 then 32 after 2 returns, frame_done 1 cycle after 2nd byte.
//  T2 copy: 'A','B' then (2,3,'C' tlast) -> issue need=4, out ABABAC, pending 0 then frame_done, err_dist=0.
//  T3 credit stall: CREDITS=16, hold returns, send (1,15,x) twice -> 2nd token held with core_in_valid=0 until 16 returns arrive.
//  T4 simultaneous: credit_return pulse on the issue cycle -> credits = old - need + 1 exactly.
//  T5 bad ref: first token (3,2,'Z') -> err_dist=1 and stays 1 across frame_done; cleared by rst.
//  T6 reset mid-drain: rst during S_DRAIN with pending=5 -> next cycle idle, credits=CREDITS, no frame_done pulse.

Source files
------------

// File: rtl/lz77_token_scheduler.sv
// ---------------------------------------------------------------------------
// lz77_token_scheduler
//
// Feeds AXI-Stream LZ77 tokens {distance, length, literal} one at a time into
// lz77_decomp_core. The core cannot be back-pressured on its output, so a
// token is only offered once the downstream byte buffer has room for every
// byte it will produce (length copies plus one literal). Credits track that
// free room. A pending counter tracks bytes issued but not yet emitted.
// At a frame boundary (tlast) the block drains until all bytes are out, then
// pulses frame_done.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   s_axis_*          token ingress (tdata = {distance, length, literal[7:0]})
//   core_in_valid     held token offered to the core
//   core_in_ready     core is idle and can take a token
//   core_distance/length/literal  held token fields (stable while offered)
//   core_out_valid    core emitted one byte this cycle
//   credit_return     downstream popped one byte
//   busy              token in flight or bytes still pending
//   frame_done        one-cycle pulse after the last byte of a frame
//   err_dist          sticky flag: illegal back-reference issued
// ---------------------------------------------------------------------------
module lz77_token_scheduler #(
    parameter int DIST_WIDTH = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int CREDITS    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [DIST_WIDTH+LEN_WIDTH+7:0] s_axis_tdata,
    input  logic                            s_axis_tlast,
    output logic                            core_in_valid,
    input  logic                            core_in_ready,
    output logic [DIST_WIDTH-1:0]           core_distance,
    output logic [LEN_WIDTH-1:0]            core_length,
    output logic [7:0]                      core_literal,
    input  logic                            core_out_valid,
    input  logic                            credit_return,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err_dist
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int NW = LEN_WIDTH + 1;
    localparam int WW = DIST_WIDTH + 1;
    localparam int SW = ((WW > NW) ? WW : NW) + 1;

    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
    localparam logic [WW-1:0] WR_MAX      = {1'b1, {DIST_WIDTH{1'b0}}};

    // The largest token must always fit into an empty buffer, otherwise it
    // could never be issued.
    generate
        if (CREDITS < (2 ** LEN_WIDTH)) begin : g_bad_credits
            $error("lz77_token_scheduler: CREDITS must be >= 2**LEN_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    // Held token and counters
    logic [DIST_WIDTH-1:0] dist_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [7:0]            lit_r;
    logic                  last_r;
    logic [CW-1:0]         credits_r;
    logic [CW-1:0]         pending_r;
    logic [WW-1:0]         wr_cnt_r;

    // Registered outputs
    logic                  valid_r;
    logic                  tready_r;
    logic                  busy_r;
    logic                  frame_done_r;
    logic                  err_r;

    // Combinational next values
    logic                  issue_s;
    logic                  load_s;
    logic                  done_s;
    logic [DIST_WIDTH-1:0] tok_dist_s;
    logic [LEN_WIDTH-1:0]  tok_len_s;
    logic [7:0]            tok_lit_s;
    logic [NW-1:0]         need_s;
    logic [NW-1:0]         need_next_s;
    logic [CW-1:0]         take_s;
    logic [CW-1:0]         cred_after_take_s;
    logic [CW-1:0]         credits_s;
    logic [CW:0]           pend_sum_s;
    logic [CW:0]           pend_adj_s;
    logic [CW-1:0]         pending_s;
    logic [SW-1:0]         wr_sum_s;
    logic [WW-1:0]         wr_cnt_s;
    logic                  bad_ref_s;
    logic                  valid_s;
    logic                  err_s;

    assign tok_dist_s = s_axis_tdata[DIST_WIDTH+LEN_WIDTH+7:LEN_WIDTH+8];
    assign tok_len_s  = s_axis_tdata[LEN_WIDTH+7:8];
    assign tok_lit_s  = s_axis_tdata[7:0];

    assign issue_s = valid_r && core_in_ready;
    assign need_s  = {1'b0, len_r} + NW'(1);

    // Credit, pending and write-count arithmetic for the coming cycle
    always_comb begin
        take_s            = {CW{1'b0}};
        cred_after_take_s = credits_r;
        credits_s         = credits_r;
        pend_sum_s        = {1'b0, pending_r};
        pend_adj_s        = {1'b0, pending_r};
        pending_s         = pending_r;
        wr_sum_s          = SW'(wr_cnt_r);
        wr_cnt_s          = wr_cnt_r;
        bad_ref_s         = 1'b0;
        err_s             = err_r;

        if (issue_s) begin
            take_s = CW'(need_s);
        end else begin
            take_s = {CW{1'b0}};
        end

        // Take first, then return: a return that would exceed the buffer
        // depth is dropped rather than wrapping the counter.
        cred_after_take_s = credits_r - take_s;
        if (credit_return && (cred_after_take_s != CREDITS_MAX)) begin
            credits_s = cred_after_take_s + CW'(1);
        end else begin
            credits_s = cred_after_take_s;
        end

        // A stray byte strobe with nothing outstanding leaves pending at 0.
        pend_sum_s = {1'b0, pending_r} + {1'b0, take_s};
        if (core_out_valid && (pend_sum_s != {(CW+1){1'b0}})) begin
            pend_adj_s = pend_sum_s - (CW+1)'(1);
        end else begin
            pend_adj_s = pend_sum_s;
        end
        pending_s = pend_adj_s[CW-1:0];

        // A copy may only reach back over bytes already written in this frame.
        bad_ref_s = (len_r != {LEN_WIDTH{1'b0}}) &&
                    ((dist_r == {DIST_WIDTH{1'b0}}) || (WW'(dist_r) > wr_cnt_r));

        wr_sum_s = SW'(wr_cnt_r) + SW'(need_s);
        if (issue_s) begin
            if (wr_sum_s >= SW'(WR_MAX)) begin
                wr_cnt_s = WR_MAX;
            end else begin
                wr_cnt_s = wr_sum_s[WW-1:0];
            end
            err_s = err_r | bad_ref_s;
        end else begin
            wr_cnt_s = wr_cnt_r;
            err_s    = err_r;
        end
    end

    // Next-state logic and the values the registered outputs will take
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        done_s      = 1'b0;
        need_next_s = need_s;
        valid_s     = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (s_axis_tvalid) begin
                    load_s  = 1'b1;
                    state_s = S_HOLD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (issue_s) begin
                    if (last_r) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (pending_s == {CW{1'b0}}) begin
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Valid is registered, so it is judged against next cycle's credits
        // and next cycle's held length. Credits only grow while a token
        // waits, so once raised it stays up until the token is issued.
        if (load_s) begin
            need_next_s = {1'b0, tok_len_s} + NW'(1);
        end else begin
            need_next_s = need_s;
        end
        valid_s = (state_s == S_HOLD) && (credits_s >= CW'(need_next_s));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: held token, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_r       <= {DIST_WIDTH{1'b0}};
            len_r        <= {LEN_WIDTH{1'b0}};
            lit_r        <= 8'd0;
            last_r       <= 1'b0;
            credits_r    <= CREDITS_MAX;
            pending_r    <= {CW{1'b0}};
            wr_cnt_r     <= {WW{1'b0}};
            valid_r      <= 1'b0;
            tready_r     <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (load_s) begin
                dist_r <= tok_dist_s;
                len_r  <= tok_len_s;
                lit_r  <= tok_lit_s;
                last_r <= s_axis_tlast;
            end
            credits_r    <= credits_s;
            pending_r    <= pending_s;
            // Issue never coincides with the end of a drain, so clearing
            // at done cannot lose an issued byte count.
            wr_cnt_r     <= done_s ? {WW{1'b0}} : wr_cnt_s;
            valid_r      <= valid_s;
            tready_r     <= (state_s == S_IDLE);
            busy_r       <= (state_s != S_IDLE) || (pending_s != {CW{1'b0}});
            frame_done_r <= done_s;
            err_r        <= err_s;
        end
    end

    assign s_axis_tready = tready_r;
    assign core_in_valid = valid_r;
    assign core_distance = dist_r;
    assign core_length   = len_r;
    assign core_literal  = lit_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign err_dist      = err_r;

endmodule
